// File: rtl/random_slot_tag_data_if.sv
// Bus between the per-tag packet source and its consumer.
//   enable      : run frames continuously while high (master -> slave)
//   tag_data    : per-tag baseband bit, registered (slave -> master)
//   frame_start : one-cycle pulse on the first TRANSMIT cycle
//   busy        : high while selecting slots or transmitting
//   collision   : high for the whole frame if any slot holds >= 2 tags
//   frame_seq   : sequence number of the current or last frame
interface random_slot_tag_data_if #(
  parameter int NUM_TAGS = 20
);
  logic                enable;
  logic [NUM_TAGS-1:0] tag_data;
  logic                frame_start;
  logic                busy;
  logic                collision;
  logic [7:0]          frame_seq;

  modport master (
    output enable,
    input  tag_data, frame_start, busy, collision, frame_seq
  );

  modport slave (
    input  enable,
    output tag_data, frame_start, busy, collision, frame_seq
  );
endinterface

// File: rtl/random_slot_tag_data.sv
// Per-tag packet source for the backscatter MAC. Each frame every tag draws
// a random slot from a shared Galois LFSR (SELECT, one tag per cycle), then
// during TRANSMIT each tag sends PREAMBLE, its 5-bit ID and the 8-bit frame
// sequence number (MSB first) only inside its own slot; otherwise its line is 0.
// Ports:
//   input_clock : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : random_slot_tag_data_if slave modport (enable in;
//                 tag_data, frame_start, busy, collision, frame_seq out)
module random_slot_tag_data #(
  parameter int          NUM_TAGS   = 20,
  parameter int          NUM_SLOTS  = 8,
  parameter int          SYMBOL_DIV = 100,
  parameter logic [7:0]  PREAMBLE   = 8'b10110010,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   input_clock,
  input  logic                   reset_n,
  random_slot_tag_data_if.slave  bus
);

  localparam int          SLOT_W   = $clog2(NUM_SLOTS);
  localparam int          DIV_W    = (SYMBOL_DIV > 1) ? $clog2(SYMBOL_DIV) : 1;
  localparam int          TAG_W    = $clog2(NUM_TAGS + 1);
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [4:0]  LAST_BIT = 5'd20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    TRANSMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [SLOT_W-1:0]   slot_q [NUM_TAGS];
  logic [SLOT_W-1:0]   slot_d [NUM_TAGS];
  logic [TAG_W-1:0]    sel_cnt_q, sel_cnt_d;
  logic [DIV_W-1:0]    sym_div_q, sym_div_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic [SLOT_W-1:0]   slot_idx_q, slot_idx_d;
  logic [NUM_TAGS-1:0] tag_data_q, tag_data_d;
  logic                frame_start_q, frame_start_d;
  logic                collision_q, collision_d;
  logic [7:0]          frame_seq_q, frame_seq_d;

  logic [NUM_SLOTS-1:0] occ;
  logic                 coll;

  // Galois right-shift LFSR, taps 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Symbol idx (0 = first transmitted) of {PREAMBLE, id, seq}, MSB first.
  function automatic logic pkt_bit(input logic [4:0] id, input logic [7:0] seq,
                                   input logic [4:0] idx);
    logic [20:0] pkt;
    pkt = {PREAMBLE, id, seq};
    return pkt[LAST_BIT - idx];
  endfunction

  // Slot table write for the tag currently being drawn. Kept apart from the
  // FSM so the occupancy check below can see the last tag's draw in the
  // same cycle the frame's collision flag is registered.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      slot_d[i] = slot_q[i];
      if (state_q == SELECT && sel_cnt_q == TAG_W'(i))
        slot_d[i] = lfsr_q[SLOT_W-1:0];
    end
  end

  always_comb begin
    occ  = '0;
    coll = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (occ[slot_d[i]]) coll = 1'b1;
      occ[slot_d[i]] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    sel_cnt_d     = sel_cnt_q;
    sym_div_d     = sym_div_q;
    bit_idx_d     = bit_idx_q;
    slot_idx_d    = slot_idx_q;
    tag_data_d    = tag_data_q;
    frame_start_d = 1'b0;
    collision_d   = collision_q;
    frame_seq_d   = frame_seq_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = SELECT;
      end

      SELECT: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (sel_cnt_q == TAG_W'(NUM_TAGS - 1)) begin
          sel_cnt_d     = '0;
          sym_div_d     = '0;
          bit_idx_d     = '0;
          slot_idx_d    = '0;
          collision_d   = coll;
          frame_start_d = 1'b1;
          state_d       = TRANSMIT;
        end else begin
          sel_cnt_d = sel_cnt_q + 1'b1;
        end
      end

      TRANSMIT: begin
        // Output register loads on the first cycle of each symbol, so the
        // line lags the symbol boundary by one cycle.
        if (sym_div_q == '0) begin
          for (int i = 0; i < NUM_TAGS; i++)
            tag_data_d[i] = (slot_q[i] == slot_idx_q) ?
                            pkt_bit(5'(i), frame_seq_q, bit_idx_q) : 1'b0;
        end
        if (sym_div_q == DIV_W'(SYMBOL_DIV - 1)) begin
          sym_div_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            if (slot_idx_q == SLOT_W'(NUM_SLOTS - 1)) begin
              slot_idx_d  = '0;
              frame_seq_d = frame_seq_q + 8'd1;
              tag_data_d  = '0;
              state_d     = bus.enable ? SELECT : IDLE;
            end else begin
              slot_idx_d = slot_idx_q + 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end else begin
          sym_div_d = sym_div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      sel_cnt_q     <= '0;
      sym_div_q     <= '0;
      bit_idx_q     <= '0;
      slot_idx_q    <= '0;
      tag_data_q    <= '0;
      frame_start_q <= 1'b0;
      collision_q   <= 1'b0;
      frame_seq_q   <= 8'd0;
      for (int i = 0; i < NUM_TAGS; i++) slot_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      sel_cnt_q     <= sel_cnt_d;
      sym_div_q     <= sym_div_d;
      bit_idx_q     <= bit_idx_d;
      slot_idx_q    <= slot_idx_d;
      tag_data_q    <= tag_data_d;
      frame_start_q <= frame_start_d;
      collision_q   <= collision_d;
      frame_seq_q   <= frame_seq_d;
      for (int i = 0; i < NUM_TAGS; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign bus.tag_data    = tag_data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.collision   = collision_q;
  assign bus.frame_seq   = frame_seq_q;

endmodule

// File: tb/tb_random_slot_tag_data.sv
module tb_random_slot_tag_data;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // DUT A: 20 tags, 8 slots, 4 cycles/symbol -> 672-cycle TRANSMIT.
  random_slot_tag_data_if #(.NUM_TAGS(20)) bus_a ();
  random_slot_tag_data #(.NUM_TAGS(20), .NUM_SLOTS(8), .SYMBOL_DIV(4)) dut_a (
    .input_clock(clk), .reset_n(rst_a_n), .bus(bus_a.slave));

  // DUT B: 3 tags, 2 slots, 2 cycles/symbol -> 3 + 84 = 87-cycle frame.
  random_slot_tag_data_if #(.NUM_TAGS(3)) bus_b ();
  random_slot_tag_data #(.NUM_TAGS(3), .NUM_SLOTS(2), .SYMBOL_DIV(2)) dut_b (
    .input_clock(clk), .reset_n(rst_b_n), .bus(bus_b.slave));

  int slots0 [20];
  int slots1 [20];

  // Hand-derived packets for frame 0.
  logic [20:0] pkt0 = 21'b10110010_00000_00000000;
  logic [20:0] pkt1 = 21'b10110010_00001_00000000;
  logic [20:0] pkt2 = 21'b10110010_00010_00000000;

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [19:0] mask_for(input int s, input int which);
    logic [19:0] m;
    m = '0;
    for (int i = 0; i < 20; i++)
      if ((which == 0 ? slots0[i] : slots1[i]) == s) m[i] = 1'b1;
    return m;
  endfunction

  task automatic wait_fs_a(input int limit, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (bus_a.frame_start === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_fs_b(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (bus_b.frame_start === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_a.tag_data !== 20'h0) begin n_err++; $display("FAIL rst_tag_data: got %h want 0", bus_a.tag_data); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.frame_start !== 1'b0) begin n_err++; $display("FAIL rst_frame_start: got %b want 0", bus_a.frame_start); end
    n_cmp++; if (bus_a.collision !== 1'b0) begin n_err++; $display("FAIL rst_collision: got %b want 0", bus_a.collision); end
    n_cmp++; if (bus_a.frame_seq !== 8'd0) begin n_err++; $display("FAIL rst_frame_seq: got %0d want 0", bus_a.frame_seq); end
    n_cmp++; if (bus_b.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_b: got %b want 0", bus_b.busy); end
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus_a.busy); end
  endtask

  // Scenario 1: 20 SELECT cycles, frame_start 21 cycles after enable sampled.
  task automatic test_select;
    bit ok;
    int n;
    bus_a.enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL select_busy: got %b want 1", bus_a.busy); end
    wait_fs_a(40, ok, n);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL select_fs_seen: got none want pulse"); end
    n_cmp++; if (n + 1 !== 21) begin n_err++; $display("FAIL select_latency: got %0d want 21", n + 1); end
    n_cmp++; if (bus_a.collision !== 1'b1) begin n_err++; $display("FAIL select_collision: got %b want 1", bus_a.collision); end
    n_cmp++; if (bus_a.frame_seq !== 8'd0) begin n_err++; $display("FAIL select_seq: got %0d want 0", bus_a.frame_seq); end
  endtask

  // Scenarios 2 and 4: frame-0 packets, enable dropped mid-TRANSMIT.
  task automatic test_packet;
    int b;
    for (int c = 1; c <= 671; c++) begin
      @(negedge clk);
      if (c == 300) bus_a.enable = 1'b0;
      if (c == 1) begin
        n_cmp++; if (bus_a.frame_start !== 1'b0) begin n_err++; $display("FAIL fs_width: got %b want 0", bus_a.frame_start); end
      end
      if (c <= 84 && (c - 1) % 4 == 1) begin
        b = (c - 1) / 4;
        n_cmp++; if (bus_a.tag_data[1] !== pkt1[20-b]) begin n_err++; $display("FAIL tag1_sym%0d: got %b want %b", b, bus_a.tag_data[1], pkt1[20-b]); end
      end
      if (c >= 85 && c <= 168 && (c - 85) % 4 == 1) begin
        b = (c - 85) / 4;
        n_cmp++; if (bus_a.tag_data[0] !== pkt0[20-b]) begin n_err++; $display("FAIL tag0_sym%0d: got %b want %b", b, bus_a.tag_data[0], pkt0[20-b]); end
      end
      if (c == 86) begin
        n_cmp++; if (bus_a.tag_data[1] !== 1'b0) begin n_err++; $display("FAIL tag1_after_slot: got %b want 0", bus_a.tag_data[1]); end
      end
      if (c % 84 == 2) begin
        n_cmp++; if (bus_a.tag_data !== mask_for(c / 84, 0)) begin n_err++; $display("FAIL f0_slot%0d_mask: got %h want %h", c / 84, bus_a.tag_data, mask_for(c / 84, 0)); end
      end
      if (c == 671) begin
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL frame_len_busy671: got %b want 1", bus_a.busy); end
      end
    end
    @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL end_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.tag_data !== 20'h0) begin n_err++; $display("FAIL end_tag_data: got %h want 0", bus_a.tag_data); end
    n_cmp++; if (bus_a.frame_seq !== 8'd1) begin n_err++; $display("FAIL end_seq: got %0d want 1", bus_a.frame_seq); end
    repeat (5) @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL idle_hold_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.collision !== 1'b1) begin n_err++; $display("FAIL idle_hold_coll: got %b want 1", bus_a.collision); end
  endtask

  // Scenario 4b: restart continues the LFSR rather than reseeding.
  task automatic test_restart;
    bit ok;
    int n;
    bus_a.enable = 1'b1;
    wait_fs_a(40, ok, n);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL restart_fs: got none want pulse"); end
    n_cmp++; if (bus_a.frame_seq !== 8'd1) begin n_err++; $display("FAIL restart_seq: got %0d want 1", bus_a.frame_seq); end
    for (int c = 1; c <= 671; c++) begin
      @(negedge clk);
      if (c % 84 == 2) begin
        n_cmp++; if (bus_a.tag_data !== mask_for(c / 84, 1)) begin n_err++; $display("FAIL f1_slot%0d_mask: got %h want %h", c / 84, bus_a.tag_data, mask_for(c / 84, 1)); end
      end
    end
  endtask

  // Scenario 5: asynchronous reset mid-slot, then frame 0 repeats.
  task automatic test_midreset;
    bit ok;
    int n;
    wait_fs_a(40, ok, n);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL f2_fs: got none want pulse"); end
    repeat (100) @(negedge clk);
    n_cmp++; if (bus_a.frame_seq !== 8'd2) begin n_err++; $display("FAIL pre_reset_seq: got %0d want 2", bus_a.frame_seq); end
    #1 rst_a_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.tag_data !== 20'h0) begin n_err++; $display("FAIL async_tag_data: got %h want 0", bus_a.tag_data); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.frame_seq !== 8'd0) begin n_err++; $display("FAIL async_seq: got %0d want 0", bus_a.frame_seq); end
    @(negedge clk);
    #1 rst_a_n = 1'b1;
    wait_fs_a(40, ok, n);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL post_reset_fs: got none want pulse"); end
    for (int c = 1; c <= 671; c++) begin
      @(negedge clk);
      if (c == 200) bus_a.enable = 1'b0;
      if (c % 84 == 2) begin
        n_cmp++; if (bus_a.tag_data !== mask_for(c / 84, 0)) begin n_err++; $display("FAIL rs_slot%0d_mask: got %h want %h", c / 84, bus_a.tag_data, mask_for(c / 84, 0)); end
      end
    end
  endtask

  // Scenario 6: seed 0xACE1 with 2 slots puts tag0 in slot 1, tags 1,2 in slot 0.
  int prev_fs_b;
  task automatic test_collision;
    bit ok;
    logic [2:0] exp;
    int b;
    bus_b.enable = 1'b1;
    wait_fs_b(20, ok);
    prev_fs_b = cyc;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL coll_fs: got none want pulse"); end
    n_cmp++; if (bus_b.collision !== 1'b1) begin n_err++; $display("FAIL coll_flag: got %b want 1", bus_b.collision); end
    for (int c = 1; c <= 83; c++) begin
      @(negedge clk);
      if (c <= 41 && c % 2 == 1) begin
        b = (c - 1) / 2;
        exp = {pkt2[20-b], pkt1[20-b], 1'b0};
        n_cmp++; if (bus_b.tag_data !== exp) begin n_err++; $display("FAIL coll_s0_sym%0d: got %b want %b", b, bus_b.tag_data, exp); end
      end
      if (c >= 43 && c % 2 == 1) begin
        b = (c - 43) / 2;
        exp = {2'b00, pkt0[20-b]};
        n_cmp++; if (bus_b.tag_data !== exp) begin n_err++; $display("FAIL coll_s1_sym%0d: got %b want %b", b, bus_b.tag_data, exp); end
      end
      if (c == 50) begin
        n_cmp++; if (bus_b.collision !== 1'b1) begin n_err++; $display("FAIL coll_hold: got %b want 1", bus_b.collision); end
      end
    end
  endtask

  // Scenario 3: 257 back-to-back frames, sequence wraps, no gap cycles.
  task automatic test_back_to_back;
    bit ok;
    for (int f = 1; f <= 256; f++) begin
      wait_fs_b(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_fs%0d: got none want pulse", f); end
      n_cmp++; if (cyc - prev_fs_b !== 87) begin n_err++; $display("FAIL b2b_period%0d: got %0d want 87", f, cyc - prev_fs_b); end
      n_cmp++; if (bus_b.frame_seq !== 8'(f)) begin n_err++; $display("FAIL b2b_seq%0d: got %0d want %0d", f, bus_b.frame_seq, f % 256); end
      prev_fs_b = cyc;
    end
    bus_b.enable = 1'b0;
  endtask

  initial begin
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < 20; i++) begin slots0[i] = int'(l[2:0]); l = step(l); end
    for (int i = 0; i < 20; i++) begin slots1[i] = int'(l[2:0]); l = step(l); end

    test_reset();
    test_select();
    test_packet();
    test_restart();
    test_midreset();
    test_collision();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/random_slot_tag_data.md
Name: random_slot_tag_data

Overview:
- Per-tag packet source for the backscatter MAC. Generates the NUM_TAGS parallel data bitstreams that the subcarrier modulation stage XNORs with the subcarrier clock.
- Each frame, every tag draws a random slot from a shared LFSR, then transmits a short packet (preamble, tag ID, frame sequence number) only during its slot.
- Outside its slot each tag's line is held at 0.

Parameters:
- NUM_TAGS, 20: number of tag data lines (max 32, because the ID field is 5 bits).
- NUM_SLOTS, 8: slots per frame; must be a power of 2, 2..16.
- SYMBOL_DIV, 100: input_clock cycles per symbol; must be ≥2.
- PREAMBLE, 8'b10110010: 8-bit preamble, sent MSB first.
- LFSR_SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- input_clock, input, 1: system clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: run frames continuously while high.
- tag_data, output, NUM_TAGS: per-tag baseband bit, registered.
- frame_start, output, 1: one-cycle pulse when the first slot begins.
- busy, output, 1: high in SELECT and TRANSMIT.
- collision, output, 1: high for the whole frame if any slot holds ≥2 tags.
- frame_seq, output, 8: sequence number of the current or last frame.

Behaviour:
- Reset (asynchronous, reset_n=0) forces: state IDLE; tag_data=0; frame_start=0; busy=0; collision=0; frame_seq=0; lfsr=LFSR_SEED; all counters 0. Reset mid-frame aborts the frame immediately. Leaving reset, the block starts in IDLE.
- LFSR: 16-bit Galois, right-shift. Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It steps only in SELECT cycles.
- State IDLE: enable is sampled every cycle. If enable=1, go to SELECT on the next edge.
- State SELECT: lasts exactly NUM_TAGS cycles, k = 0..NUM_TAGS-1.
  - In cycle k: slot_reg[k] <= lfsr[log2(NUM_SLOTS)-1:0], then lfsr steps.
  - After the last cycle: go to TRANSMIT. Register collision from the slot_reg occupancy. Assert frame_start for exactly 1 cycle, coincident with the first TRANSMIT cycle.
- State TRANSMIT:
  - Packet is PKT = 21 symbols: PREAMBLE[7:0], tag ID i[4:0], frame_seq[7:0], each MSB first.
  - Counters: sym_div counts 0..SYMBOL_DIV-1; bit_idx counts 0..20; slot_idx counts 0..NUM_SLOTS-1.
  - Frame length is NUM_SLOTS*21*SYMBOL_DIV cycles.
  - tag_data[i] <= (slot_reg[i]==slot_idx) ? packet_i[bit_idx] : 0. It is updated when sym_div==0, so it lags the symbol boundary by 1 cycle and is held constant for SYMBOL_DIV cycles.
  - After the final symbol of the last slot: frame_seq increments (wraps 255→0) and tag_data goes to 0.
  - If enable=1: go to SELECT, with no idle cycles between frames. If enable=0: go to IDLE.
- enable deasserted mid-frame: the current frame completes normally, then the block enters IDLE. enable pulses in SELECT or TRANSMIT are ignored.
- Multiple tags in one slot: all of them drive their packets simultaneously, and collision=1 for that frame. Collisions are not arbitrated.
- Empty slots: all tag_data lines are 0 for the slot duration.
- collision and frame_seq hold their values in IDLE.
- busy=1 exactly while the state is SELECT or TRANSMIT.

Test Plan:
1. Reset, then enable=1 with defaults and SYMBOL_DIV=4:
   - SELECT lasts 20 cycles.
   - slot_reg[0]=1 (lfsr 0xACE1); slot_reg[1]=0 (lfsr 0xE270).
   - frame_start pulses once, 21 cycles after enable is sampled.
2. Frame 0 with the seed from scenario 1:
   - tag_data[1] shows 10110010 00001 00000000 during cycles 1..84 of TRANSMIT, then 0.
   - tag_data[0] shows 10110010 00000 00000000 during slot 1.
3. Continuous enable for 257 frames:
   - frame_seq goes 0,1,…,255,0.
   - No gap cycles between a frame's last symbol and the next SELECT.
4. enable dropped mid-TRANSMIT:
   - The frame runs to its full 672 cycles (SYMBOL_DIV=4), then IDLE with busy=0 and tag_data=0.
   - A later enable restarts with the LFSR continuing from its current value, not from the seed.
5. reset_n pulsed low mid-slot:
   - tag_data=0, busy=0, frame_seq=0 asynchronously.
   - After release with enable=1, the frame-0 slot assignment repeats exactly as in scenario 1.
6. Force two tags to draw the same slot (NUM_SLOTS=2, NUM_TAGS=3):
   - collision=1 for the frame.
   - Both colliding lines carry identical preamble symbols and different ID bits in that slot.
